hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_if.sv | 30 +++
 rtl/hazard_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned REG_W           = 5;
    localparam int unsigned INIT_CYCLES_DEF = 2;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave is hazard_ctrl.
interface hazard_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic             ResultSrcE0, PCSrcE;
    logic [4:0]       RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount, FlushCount;
    logic             MemTimeout;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, StallCount, FlushCount, MemTimeout
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, StallCount, FlushCount, MemTimeout
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one Execute source; Memory stage beats Writeback.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] i_rs_e,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic             i_reg_write_m,
    input  logic [REG_W-1:0] i_rd_w,
    input  logic             i_reg_write_w,
    input  logic             i_en,
    output fwd_sel_t         o_sel_c
);

    always_comb begin
        o_sel_c = FWD_RF;
        if (i_en) begin
            if (i_reg_write_m && (i_rd_m != REG_W'(0)) && (i_rd_m == i_rs_e)) begin
                o_sel_c = FWD_M;
            end else if (i_reg_write_w && (i_rd_w != REG_W'(0)) && (i_rd_w == i_rs_e)) begin
                o_sel_c = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: post-reset flush, load-use/branch handling, memory-wait stall,
// operand forwarding and saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);

    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 2);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

    hz_state_t         r_state, w_state_nxt;
    logic [INIT_W-1:0] r_init_cnt, w_init_cnt_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              r_mem_timeout;

    logic w_lw_stall, w_run, w_mem_stall, w_flush_evt, w_any_stall;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_w;
    fwd_sel_t w_fwd_a, w_fwd_b;

    hazard_fwd_sel u_fwd_a (
        .i_rs_e        (hz.Rs1E),
        .i_rd_m        (hz.RdM),
        .i_reg_write_m (hz.RegWriteM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_w (hz.RegWriteW),
        .i_en          (!rst),
        .o_sel_c       (w_fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .i_rs_e        (hz.Rs2E),
        .i_rd_m        (hz.RdM),
        .i_reg_write_m (hz.RegWriteM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_w (hz.RegWriteW),
        .i_en          (!rst),
        .o_sel_c       (w_fwd_b)
    );

    // Next state and hazard outputs; the cycle MemReadyM arrives in MEMWAIT behaves as RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_stall_f      = 1'b0;
        w_stall_d      = 1'b0;
        w_stall_e      = 1'b0;
        w_stall_m      = 1'b0;
        w_flush_d      = 1'b0;
        w_flush_e      = 1'b0;
        w_flush_w      = 1'b0;
        w_flush_evt    = 1'b0;

        w_lw_stall  = hz.ResultSrcE0 && (hz.RdE != REG_W'(0)) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        w_run       = (r_state == RUN) || ((r_state == MEMWAIT) && hz.MemReadyM);
        w_mem_stall = (((r_state == RUN) && hz.MemReqM) || (r_state == MEMWAIT)) &&
                      !hz.MemReadyM;

        if (rst) begin
            w_state_nxt = INIT;
            w_flush_d   = 1'b1;
            w_flush_e   = 1'b1;
            w_flush_w   = 1'b1;
        end else begin
            case (r_state)
                INIT: begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    w_flush_w = 1'b1;
                    if ((32'(r_init_cnt) + 32'd1) >= INIT_CYCLES) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
                    end
                end
                RUN: begin
                    if (w_mem_stall) begin
                        w_state_nxt    = MEMWAIT;
                        w_wait_cnt_nxt = '0;
                    end
                end
                MEMWAIT: begin
                    if (hz.MemReadyM) begin
                        w_state_nxt = RUN;
                    end else if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: w_state_nxt = INIT;
            endcase

            // A stalled memory stage freezes the whole pipe, so branches wait too.
            if (w_mem_stall) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_stall_m = 1'b1;
                w_flush_w = 1'b1;
            end else if (w_run) begin
                if (hz.PCSrcE) begin
                    w_flush_d   = 1'b1;
                    w_flush_e   = 1'b1;
                    w_flush_evt = 1'b1;
                end else if (w_lw_stall) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
        end

        w_any_stall = w_stall_f || w_stall_d || w_stall_e || w_stall_m;
    end

    // State, counters and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= INIT;
            r_init_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_any_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if ((w_state_nxt == MEMWAIT) && (w_wait_cnt_nxt == WAIT_W'(MEM_TIMEOUT))) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign hz.StallF     = w_stall_f;
    assign hz.StallD     = w_stall_d;
    assign hz.StallE     = w_stall_e;
    assign hz.StallM     = w_stall_m;
    assign hz.FlushD     = w_flush_d;
    assign hz.FlushE     = w_flush_e;
    assign hz.FlushW     = w_flush_w;
    assign hz.ForwardAE  = w_fwd_a;
    assign hz.ForwardBE  = w_fwd_b;
    assign hz.StallCount = r_stall_cnt;
    assign hz.FlushCount = r_flush_cnt;
    assign hz.MemTimeout = r_mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a 4-bit-counter instance.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_if #(.CNT_W(32)) hz  ();
    hazard_if #(.CNT_W(4))  hzb ();

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    hazard_ctrl #(.CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (hzb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
        hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
        hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        hzb.Rs1D = '0; hzb.Rs2D = '0; hzb.Rs1E = '0; hzb.Rs2E = '0; hzb.RdE = '0;
        hzb.ResultSrcE0 = 1'b0; hzb.PCSrcE = 1'b0;
        hzb.RdM = '0; hzb.RdW = '0; hzb.RegWriteM = 1'b0; hzb.RegWriteW = 1'b0;
        hzb.MemReqM = 1'b0; hzb.MemReadyM = 1'b0;

        // Reset: outputs forced regardless of a matching forward source
        hz.RdM = 5'd5; hz.Rs1E = 5'd5; hz.RegWriteM = 1'b1;
        #1;
        chk("rst_fwd_a", 32'(hz.ForwardAE), 32'd0);
        chk("rst_flush", 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'b111);
        chk("rst_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'd0);
        repeat (3) cyc();
        chk("rst_stallcnt", hz.StallCount, 32'd0);
        chk("rst_flushcnt", hz.FlushCount, 32'd0);
        chk("rst_timeout", 32'(hz.MemTimeout), 32'd0);
        rst = 1'b0;
        idle();

        // INIT flushes for exactly two cycles after release
        #1;
        chk("init1_flush", 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'b111);
        chk("init1_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'd0);
        cyc();
        chk("init2_flush", 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'b111);
        cyc();
        chk("run_flush", 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'd0);
        chk("run_cnt0", hz.StallCount, 32'd0);

        // Forwarding priority
        hz.RdM = 5'd5; hz.RdW = 5'd5; hz.Rs1E = 5'd5; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
        #1;
        chk("fwd_m_prio", 32'(hz.ForwardAE), 32'b10);
        chk("fwd_b_none", 32'(hz.ForwardBE), 32'b00);
        hz.RdM = 5'd0;
        #1;
        chk("fwd_w", 32'(hz.ForwardAE), 32'b01);
        hz.Rs1E = 5'd0; hz.RdW = 5'd0;
        #1;
        chk("fwd_x0", 32'(hz.ForwardAE), 32'b00);
        hz.Rs2E = 5'd9; hz.RdW = 5'd9; hz.RdM = 5'd9; hz.RegWriteM = 1'b0;
        #1;
        chk("fwd_b_w", 32'(hz.ForwardBE), 32'b01);
        idle();

        // Load-use stall, then coincident with a taken branch
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        chk("lw_outs", 32'({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.StallE}), 32'b11100);
        cyc();
        chk("lw_stallcnt", hz.StallCount, 32'd1);
        hz.PCSrcE = 1'b1;
        #1;
        chk("lw_br_stallf", 32'({hz.StallF, hz.StallD}), 32'd0);
        chk("lw_br_flush", 32'({hz.FlushD, hz.FlushE}), 32'b11);
        cyc();
        idle();
        #1;
        chk("br_flushcnt", hz.FlushCount, 32'd1);
        chk("br_stallcnt", hz.StallCount, 32'd1);
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd0;
        #1;
        chk("lw_x0", 32'(hz.StallF), 32'd0);
        idle();

        // Memory wait: four low cycles, branch pulse ignored
        hz.MemReqM = 1'b1;
        #1;
        chk("mw1_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'b11111);
        cyc();
        hz.PCSrcE = 1'b1;
        #1;
        chk("mw2_pc_ign", 32'({hz.FlushD, hz.FlushE}), 32'd0);
        chk("mw2_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'b11111);
        cyc();
        hz.PCSrcE = 1'b0;
        #1;
        chk("mw3_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'hF);
        cyc();
        chk("mw4_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'hF);
        cyc();
        hz.MemReadyM = 1'b1;
        #1;
        chk("mw_ready", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'd0);
        cyc();
        idle();
        #1;
        chk("mw_stallcnt", hz.StallCount, 32'd5);
        chk("mw_flushcnt", hz.FlushCount, 32'd1);
        chk("mw_no_to", 32'(hz.MemTimeout), 32'd0);

        // Timeout after 255 waiting cycles; sticky past ready
        hz.MemReqM = 1'b1;
        cyc();
        repeat (254) cyc();
        chk("to_254", 32'(hz.MemTimeout), 32'd0);
        cyc();
        chk("to_255", 32'(hz.MemTimeout), 32'd1);
        repeat (44) cyc();
        chk("to_still_wait", 32'(hz.StallM), 32'd1);
        hz.MemReadyM = 1'b1;
        #1;
        chk("to_ready", 32'(hz.StallF), 32'd0);
        cyc();
        idle();
        #1;
        chk("to_sticky", 32'(hz.MemTimeout), 32'd1);
        chk("to_stallcnt", hz.StallCount, 32'd305);

        // Reset in the middle of a memory wait
        hz.MemReqM = 1'b1;
        cyc();
        chk("rmw_wait", 32'(hz.StallE), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw_rst_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'd0);
        chk("rmw_rst_flush", 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'b111);
        cyc();
        rst = 1'b0;
        hz.MemReadyM = 1'b1;
        #1;
        chk("rmw_init_stall", 32'(hz.StallF), 32'd0);
        chk("rmw_init_flush", 32'(hz.FlushD), 32'd1);
        chk("rmw_timeout", 32'(hz.MemTimeout), 32'd0);
        chk("rmw_stallcnt", hz.StallCount, 32'd0);
        cyc();
        chk("rmw_init2", 32'(hz.FlushE), 32'd1);
        cyc();
        chk("rmw_run", 32'({hz.FlushD, hz.StallF}), 32'd0);
        idle();

        // Saturation of a 4-bit stall counter
        hzb.MemReqM = 1'b1;
        repeat (14) cyc();
        chk("sat_14", 32'(hzb.StallCount), 32'd14);
        repeat (6) cyc();
        chk("sat_20", 32'(hzb.StallCount), 32'd15);
        hzb.MemReadyM = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
